fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Parametrised instruction-fetch front end for the next-generation (pipelined) RV32I core. Replaces the single-cycle PC/instruction-memory path.
- Holds the fetch PC and waits for `trigger` before starting. Issues requests to a fixed-latency instruction memory and buffers returned instructions in a prefetch FIFO.
- Presents instructions to decode with a valid/ready handshake. Accepts branch/jump redirects from execute, flushing all wrong-path state.

Parameters:
- DATA_WIDTH, 32, instruction word width.
- ADDR_WIDTH, 32, PC / instruction-memory address width.
- FIFO_DEPTH, 4, prefetch buffer entries; power of two, >= 2.
- RESET_PC, 32'h0000_0000, PC loaded at reset; must be 4-byte aligned.

Ports:
- clk, input, 1, sole clock; all state on its rising edge.
- rst, input, 1, asynchronous, active-low reset.
- trigger, input, 1, start strobe; first sampled high moves the unit IDLE -> RUN.
- redirect_valid, input, 1, execute-stage branch/jal/jalr taken.
- redirect_pc, input, ADDR_WIDTH, redirect target; bits [1:0] ignored (forced to 00).
- imem_req, output, 1, instruction-memory read request this cycle.
- imem_addr, output, ADDR_WIDTH, read address; valid when imem_req=1.
- imem_rdata, input, DATA_WIDTH, read data, valid exactly 1 cycle after imem_req.
- instr_valid, output, 1, FIFO head is valid.
- instr_ready, input, 1, decode accepts the head.
- instr, output, DATA_WIDTH, head instruction.
- instr_pc, output, ADDR_WIDTH, PC of the head instruction.
- instr_pc_plus4, output, ADDR_WIDTH, instr_pc + 4 (modulo 2^ADDR_WIDTH), used as the jal/jalr link value.
- running, output, 1, high in RUN.

Behaviour:
- **Reset (rst=0, asynchronous, takes effect immediately):**
  - state=IDLE, fetch_pc=RESET_PC, FIFO emptied and storage cleared, in-flight flag cleared, kill flag cleared.
  - Outputs: imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, instr_pc_plus4=4, running=0.
  - Reset mid-operation discards all buffered and in-flight work; after release the unit waits for trigger again.
- **FSM:**
  - IDLE -> RUN when trigger=1 at a clock edge.
  - RUN is terminal until reset; trigger is ignored in RUN.
  - No requests are issued in IDLE.
  - A redirect in IDLE loads fetch_pc only.
- **Request rule (RUN):**
  - imem_req=1 iff redirect_valid=0 and (count + inflight < FIFO_DEPTH, or count + inflight == FIFO_DEPTH with a pop this cycle).
  - imem_addr=fetch_pc; on a request, fetch_pc <= fetch_pc + 4, wrapping modulo 2^ADDR_WIDTH.
- **Response:**
  - inflight <= imem_req each cycle.
  - The cycle after a request, {imem_rdata, pc} is pushed unless the kill flag is set; in that case the response is dropped and kill clears.
  - Overflow is impossible by the credit rule; an assertion must check this.
- **Latency:**
  - trigger sampled at edge 0 -> imem_req at RESET_PC in cycle 1 -> push at edge 2 -> instr_valid=1 in cycle 2+1 (3 cycles from trigger).
  - There is no FIFO bypass.
- **Throughput:** with instr_ready held high, one instruction per cycle sustained for any FIFO_DEPTH >= 2.
- **Handshake:**
  - Pop when instr_valid & instr_ready & !redirect_valid.
  - instr/instr_pc stay stable while valid and not accepted.
  - Simultaneous push and pop is legal; count is unchanged.
- **Redirect (priority over everything):**
  - In the redirect cycle: no request, no pop, and an arriving response is not pushed.
  - At the edge: FIFO flushed; kill <= inflight of this cycle (a request issued the cycle before is dropped on return); fetch_pc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00}.
  - Next cycle: imem_req at the new PC. The first redirected instruction is valid 3 cycles after the redirect cycle.
  - Back-to-back redirects: the last one wins.
- **Full/empty:** instr_valid = !empty; the FIFO count ranges 0..FIFO_DEPTH, with pointers of width log2(FIFO_DEPTH) plus a count register.

Decomposition:
- Package `fetch_pkg`:
  - fetch_state_t enum {IDLE, RUN}.
  - fetch_entry_t struct {instr, pc}.
  - Constant NOP_INSTR = 32'h0000_0013 (for downstream bubble insertion).
  - Default RESET_PC constant.
- Sub-module `fetch_fifo`: synchronous FIFO with parameter FIFO_DEPTH, push/pop/flush, count output, async active-low reset. fetch_unit holds the FSM, fetch_pc, credit, inflight and kill logic.

Test Plan:
1. Reset, trigger=0 for 20 cycles -> imem_req=0, instr_valid=0, running=0, imem_addr=0.
2. Trigger pulse at cycle 0; memory model returns rdata=addr^32'hA5A5_0000; instr_ready=1 -> imem_addr 0,4,8,...; instr_valid from cycle 3; instr_pc 0,4,8,12 on consecutive cycles with no gaps; instr_pc_plus4 = instr_pc+4.
3. FIFO_DEPTH=4, instr_ready=0 for 10 cycles mid-run -> imem_req deasserts once 4 entries are buffered; instr_pc frozen. instr_ready=1 -> PCs continue in order with no loss or duplicate.
4. Redirect to 32'h0000_0102 while 3 entries are buffered and one response is in flight -> instr_valid=0 the next cycle, the in-flight word is never presented, next imem_addr=32'h100, first valid instr_pc=32'h100 three cycles after the redirect.
5. RESET_PC=32'hFFFF_FFF8, trigger -> fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004; a redirect and a pop requested in the same cycle -> no pop occurs and the FIFO is flushed.
6. rst asserted asynchronously mid-cycle during streaming -> all outputs return to reset values before the next edge. After release, no request until trigger; restart at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch front end
package fetch_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    // Canonical RV32I nop (addi x0, x0, 0) for downstream bubble insertion
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction-memory and decode-side signals of the fetch unit
interface fetch_unit_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  imem_req;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [DATA_WIDTH-1:0] imem_rdata;
    logic                  instr_valid;
    logic                  instr_ready;
    logic [DATA_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0] instr_pc;
    logic [ADDR_WIDTH-1:0] instr_pc_plus4;

    modport master (
        output imem_req, imem_addr,
        input  imem_rdata,
        output instr_valid, instr, instr_pc, instr_pc_plus4,
        input  instr_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_rdata,
        input  instr_valid, instr, instr_pc, instr_pc_plus4,
        output instr_ready
    );
endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - prefetch buffer: power-of-two synchronous FIFO with flush
module fetch_fifo #(
    parameter int WIDTH      = 64,
    parameter int FIFO_DEPTH = 4,
    localparam int PTR_W     = $clog2(FIFO_DEPTH),
    localparam int CNT_W     = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o
);
    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full || do_pop);
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // The credit rule upstream must never let a push reach a full buffer
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push_i && !flush_i && full && !pop_i));

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32I fetch front end: PC, credit-based imem requests,
// prefetch buffer and redirect flush
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int DATA_WIDTH                = 32,
    parameter int ADDR_WIDTH                = 32,
    parameter int FIFO_DEPTH                = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  trigger,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  running,
    fetch_unit_if.master          bus
);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = DATA_WIDTH + ADDR_WIDTH;

    fetch_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_WIDTH-1:0] resp_pc_q;
    logic                  inflight_q, inflight_d;
    logic                  kill_q, kill_d;
    logic                  req;
    logic                  push;
    logic                  pop;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    logic [CNT_W:0]        occupancy;
    logic [ENTRY_W-1:0]    head_entry;

    // Slots already committed: buffered entries plus the response still on its way
    assign occupancy = {1'b0, fifo_count} + (CNT_W + 1)'(inflight_q);
    assign pop       = !fifo_empty && bus.instr_ready && !redirect_valid;
    assign push      = inflight_q && !kill_q && !redirect_valid;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        kill_d     = kill_q;
        req        = 1'b0;
        case (state_q)
            IDLE: begin
                if (trigger) state_d = RUN;
            end
            RUN: begin
                req = !redirect_valid &&
                      ((occupancy < (CNT_W + 1)'(FIFO_DEPTH)) ||
                       ((occupancy == (CNT_W + 1)'(FIFO_DEPTH)) && pop));
            end
            default: state_d = IDLE;
        endcase
        inflight_d = req;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & ~ADDR_WIDTH'(3);
            kill_d     = inflight_d;
        end else begin
            if (req) fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
            if (inflight_q) kill_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= '0;
            inflight_q <= 1'b0;
            kill_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= inflight_d;
            kill_q     <= kill_d;
            if (req) resp_pc_q <= fetch_pc_q;
        end
    end

    fetch_fifo #(
        .WIDTH      (ENTRY_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .flush_i (redirect_valid),
        .push_i  (push),
        .wdata_i ({bus.imem_rdata, resp_pc_q}),
        .pop_i   (pop),
        .rdata_o (head_entry),
        .count_o (fifo_count),
        .empty_o (fifo_empty)
    );

    assign bus.imem_req       = req;
    assign bus.imem_addr      = fetch_pc_q;
    assign bus.instr_valid    = !fifo_empty;
    assign {bus.instr, bus.instr_pc} = fifo_empty ? '0 : head_entry;
    assign bus.instr_pc_plus4 = bus.instr_pc + ADDR_WIDTH'(4);
    assign running            = (state_q == RUN);

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam logic [31:0] MASK    = 32'hA5A5_0000;
    localparam logic [31:0] RESET_B = 32'hFFFF_FFF8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, trig_a, redir_a, running_a;
    logic [31:0] redir_pc_a;
    logic        rst_b, trig_b, redir_b, running_b;
    logic [31:0] redir_pc_b;

    fetch_unit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus_a ();
    fetch_unit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus_b ();

    fetch_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .FIFO_DEPTH(4), .RESET_PC(32'h0)) dut_a (
        .clk(clk), .rst(rst_a), .trigger(trig_a), .redirect_valid(redir_a),
        .redirect_pc(redir_pc_a), .running(running_a), .bus(bus_a)
    );

    fetch_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .FIFO_DEPTH(4), .RESET_PC(RESET_B)) dut_b (
        .clk(clk), .rst(rst_b), .trigger(trig_b), .redirect_valid(redir_b),
        .redirect_pc(redir_pc_b), .running(running_b), .bus(bus_b)
    );

    always @(posedge clk) begin
        bus_a.imem_rdata <= bus_a.imem_req ? (bus_a.imem_addr ^ MASK) : NOP_INSTR;
        bus_b.imem_rdata <= bus_b.imem_req ? (bus_b.imem_addr ^ MASK) : NOP_INSTR;
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    fetch_entry_t exp_q[$];

    task automatic sb_load(input logic [31:0] start);
        fetch_entry_t e;
        exp_q.delete();
        for (int i = 0; i < 64; i++) begin
            e.pc    = start + 32'(4 * i);
            e.instr = e.pc ^ MASK;
            exp_q.push_back(e);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor for dut_a: address model and scoreboard of accepted instructions
    logic [31:0]  exp_addr_a = 32'h0;
    fetch_entry_t mon_e;
    always @(negedge clk) begin
        if (!rst_a) begin
            exp_addr_a <= 32'h0;
        end else begin
            if (redir_a) begin
                check("redir_no_req", 64'(bus_a.imem_req), 64'd0);
                exp_addr_a <= redir_pc_a & ~32'h3;
            end else if (bus_a.imem_req) begin
                check("imem_addr", 64'(bus_a.imem_addr), 64'(exp_addr_a));
                exp_addr_a <= exp_addr_a + 32'd4;
            end
            if (bus_a.instr_valid && bus_a.instr_ready && !redir_a) begin
                check("sb_avail", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("sb_pc",    64'(bus_a.instr_pc),       64'(mon_e.pc));
                    check("sb_instr", 64'(bus_a.instr),          64'(mon_e.instr));
                    check("sb_plus4", 64'(bus_a.instr_pc_plus4), 64'(mon_e.pc + 32'd4));
                end
            end
        end
    end

    initial begin
        rst_a = 1'b0; trig_a = 1'b0; redir_a = 1'b0; redir_pc_a = '0;
        rst_b = 1'b0; trig_b = 1'b0; redir_b = 1'b0; redir_pc_b = '0;
        bus_a.instr_ready = 1'b0;
        bus_b.instr_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req",    64'(bus_a.imem_req),       64'd0);
        check("rst_addr",   64'(bus_a.imem_addr),      64'd0);
        check("rst_valid",  64'(bus_a.instr_valid),    64'd0);
        check("rst_instr",  64'(bus_a.instr),          64'd0);
        check("rst_pc",     64'(bus_a.instr_pc),       64'd0);
        check("rst_plus4",  64'(bus_a.instr_pc_plus4), 64'd4);
        check("rst_run",    64'(running_a),            64'd0);
        check("rst_addr_b", 64'(bus_b.imem_addr),      64'(RESET_B));

        next_cycle(); rst_a = 1'b1; rst_b = 1'b1;
        for (int i = 0; i < 20; i++) begin
            next_cycle(); @(negedge clk);
            check("idle_req",   64'(bus_a.imem_req),    64'd0);
            check("idle_valid", 64'(bus_a.instr_valid), 64'd0);
            check("idle_run",   64'(running_a),         64'd0);
            check("idle_addr",  64'(bus_a.imem_addr),   64'd0);
        end

        // Trigger: cycle 0 is the cycle whose closing edge samples it
        next_cycle(); trig_a = 1'b1; bus_a.instr_ready = 1'b1; sb_load(32'h0);
        next_cycle(); trig_a = 1'b0; @(negedge clk);
        check("c1_req",   64'(bus_a.imem_req),    64'd1);
        check("c1_run",   64'(running_a),         64'd1);
        check("c1_valid", 64'(bus_a.instr_valid), 64'd0);
        next_cycle(); @(negedge clk);
        check("c2_valid", 64'(bus_a.instr_valid), 64'd0);
        for (int k = 3; k < 15; k++) begin
            next_cycle(); @(negedge clk);
            check("stream_valid", 64'(bus_a.instr_valid), 64'd1);
            check("stream_pc",    64'(bus_a.instr_pc),    64'(4 * (k - 3)));
        end

        // Stall for 10 cycles: buffer fills, requests stop, head frozen
        for (int s = 0; s < 10; s++) begin
            next_cycle(); bus_a.instr_ready = 1'b0; @(negedge clk);
            check("stall_valid", 64'(bus_a.instr_valid), 64'd1);
            check("stall_pc",    64'(bus_a.instr_pc),    64'd48);
            if (s >= 2) check("stall_no_req", 64'(bus_a.imem_req), 64'd0);
        end
        for (int r = 0; r < 6; r++) begin
            next_cycle(); bus_a.instr_ready = 1'b1; @(negedge clk);
            check("resume_valid", 64'(bus_a.instr_valid), 64'd1);
        end
        for (int s = 0; s < 6; s++) begin
            next_cycle(); bus_a.instr_ready = 1'b0; @(negedge clk);
            check("stall2_pc", 64'(bus_a.instr_pc), 64'd72);
            if (s >= 1) check("stall2_no_req", 64'(bus_a.imem_req), 64'd0);
        end
        next_cycle(); bus_a.instr_ready = 1'b1;

        // Redirect with 3 buffered and one response in flight
        next_cycle(); redir_a = 1'b1; redir_pc_a = 32'h0000_0102; sb_load(32'h100);
        @(negedge clk);
        check("redir_head_valid", 64'(bus_a.instr_valid), 64'd1);
        check("redir_head_pc",    64'(bus_a.instr_pc),    64'h4C);
        next_cycle(); redir_a = 1'b0; @(negedge clk);
        check("r1_valid", 64'(bus_a.instr_valid), 64'd0);
        check("r1_req",   64'(bus_a.imem_req),    64'd1);
        check("r1_addr",  64'(bus_a.imem_addr),   64'h100);
        next_cycle(); @(negedge clk);
        check("r2_valid", 64'(bus_a.instr_valid), 64'd0);
        next_cycle(); @(negedge clk);
        check("r3_valid", 64'(bus_a.instr_valid), 64'd1);
        check("r3_pc",    64'(bus_a.instr_pc),    64'h100);
        repeat (5) next_cycle();

        // Back-to-back redirects: the second target wins
        next_cycle(); redir_a = 1'b1; redir_pc_a = 32'h200; sb_load(32'h200);
        next_cycle(); redir_pc_a = 32'h300; sb_load(32'h300);
        next_cycle(); redir_a = 1'b0; @(negedge clk);
        check("b2b_addr",  64'(bus_a.imem_addr),   64'h300);
        check("b2b_req",   64'(bus_a.imem_req),    64'd1);
        check("b2b_valid", 64'(bus_a.instr_valid), 64'd0);
        next_cycle(); next_cycle(); @(negedge clk);
        check("b2b_pc", 64'(bus_a.instr_pc), 64'h300);
        repeat (4) next_cycle();

        // Asynchronous reset in the middle of a cycle while streaming
        @(posedge clk); #3;
        rst_a = 1'b0; exp_q.delete();
        #1;
        check("arst_req",   64'(bus_a.imem_req),       64'd0);
        check("arst_addr",  64'(bus_a.imem_addr),      64'd0);
        check("arst_valid", 64'(bus_a.instr_valid),    64'd0);
        check("arst_instr", 64'(bus_a.instr),          64'd0);
        check("arst_pc",    64'(bus_a.instr_pc),       64'd0);
        check("arst_plus4", 64'(bus_a.instr_pc_plus4), 64'd4);
        check("arst_run",   64'(running_a),            64'd0);
        next_cycle(); rst_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            next_cycle(); @(negedge clk);
            check("post_rst_req", 64'(bus_a.imem_req), 64'd0);
            check("post_rst_run", 64'(running_a),      64'd0);
        end
        next_cycle(); trig_a = 1'b1; sb_load(32'h0);
        next_cycle(); trig_a = 1'b0; @(negedge clk);
        check("restart_req",  64'(bus_a.imem_req),  64'd1);
        check("restart_addr", 64'(bus_a.imem_addr), 64'd0);
        next_cycle(); next_cycle(); @(negedge clk);
        check("restart_valid", 64'(bus_a.instr_valid), 64'd1);
        check("restart_pc",    64'(bus_a.instr_pc),    64'd0);
        repeat (4) next_cycle();

        // Address wrap from a high reset PC, then redirect on a pop cycle
        next_cycle(); trig_b = 1'b1; bus_b.instr_ready = 1'b1;
        next_cycle(); trig_b = 1'b0; @(negedge clk);
        check("w_run",   64'(running_b),       64'd1);
        check("w_req1",  64'(bus_b.imem_req),  64'd1);
        check("w_addr1", 64'(bus_b.imem_addr), 64'hFFFF_FFF8);
        next_cycle(); @(negedge clk);
        check("w_addr2", 64'(bus_b.imem_addr), 64'hFFFF_FFFC);
        next_cycle(); @(negedge clk);
        check("w_addr3",  64'(bus_b.imem_addr), 64'h0);
        check("w_pc3",    64'(bus_b.instr_pc),  64'hFFFF_FFF8);
        check("w_instr3", 64'(bus_b.instr),     64'(RESET_B ^ MASK));
        next_cycle(); @(negedge clk);
        check("w_addr4",  64'(bus_b.imem_addr),      64'h4);
        check("w_pc4",    64'(bus_b.instr_pc),       64'hFFFF_FFFC);
        check("w_plus4",  64'(bus_b.instr_pc_plus4), 64'h0);
        next_cycle(); redir_b = 1'b1; redir_pc_b = 32'h43; @(negedge clk);
        check("wr_req",   64'(bus_b.imem_req),    64'd0);
        check("wr_valid", 64'(bus_b.instr_valid), 64'd1);
        check("wr_pc",    64'(bus_b.instr_pc),    64'h0);
        next_cycle(); redir_b = 1'b0; @(negedge clk);
        check("wr1_valid", 64'(bus_b.instr_valid), 64'd0);
        check("wr1_addr",  64'(bus_b.imem_addr),   64'h40);
        next_cycle(); @(negedge clk);
        check("wr2_valid", 64'(bus_b.instr_valid), 64'd0);
        next_cycle(); @(negedge clk);
        check("wr3_valid", 64'(bus_b.instr_valid), 64'd1);
        check("wr3_pc",    64'(bus_b.instr_pc),    64'h40);
        check("wr3_instr", 64'(bus_b.instr),       64'(32'h40 ^ MASK));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
